// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator for a single-port,
// word-indexed data memory. Sub-word stores are done as read-modify-write;
// loads are lane-extracted and sign/zero-extended from the returned word.
`timescale 1ns/1ps

module mem_access_unit #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] Mem_address,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_Data
);

  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  localparam logic [1:0]  SZ_ILL     = 2'b11;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic        we_reg;
  logic        unsigned_reg;
  logic [15:0] wdata_reg;
  logic [31:0] rdbuf_reg;
  logic [31:0] rdbuf_next;

  logic        rsp_valid_reg;
  logic [31:0] rsp_data_reg;
  logic        rsp_err_reg;
  logic [31:0] mem_address_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [31:0] write_data_reg;

  // Request decode (evaluated on the raw request, used only at accept)
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_error;
  logic        req_word_store;
  logic [31:0] req_index;

  // Lane datapath
  logic [7:0]  rd_bytes [4];
  logic [3:0]  lane_en;
  logic [31:0] store_rep;
  logic [31:0] merged_word;
  logic [31:0] load_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req_ready   = (state_reg == IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign Mem_address = mem_address_reg;
  assign Mem_read    = mem_read_reg;
  assign Mem_write   = mem_write_reg;
  assign Write_data  = write_data_reg;

  assign req_out_of_range = ({1'b0, req_addr} >= ADDR_LIMIT);
  assign req_error        = (req_size == SZ_ILL) || req_misaligned || req_out_of_range;
  assign req_word_store   = req_we && (req_size == SZ_WORD);
  assign req_index        = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS+1:2]};

  // Alignment rule depends on access size; bytes are always aligned
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SZ_HALF: req_misaligned = req_addr[0];
      SZ_WORD: req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // The word being returned is only valid on the RD exit edge; use it
  // directly there so merge/extract results can be registered in the same edge
  assign rdbuf_next = (state_reg == RD) ? Read_Data : rdbuf_reg;

  // Byte lanes being replaced by a store (little-endian lane numbering)
  always_comb begin
    lane_en = 4'b0000;
    case (size_reg)
      SZ_BYTE: lane_en[lane_reg] = 1'b1;
      SZ_HALF: lane_en = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Store data replicated into every lane so each lane mux sees its own copy
  assign store_rep = (size_reg == SZ_BYTE) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_bytes[gi]              = rdbuf_next[8*gi +: 8];
      assign merged_word[8*gi +: 8]    = lane_en[gi] ? store_rep[8*gi +: 8] : rd_bytes[gi];
    end
  endgenerate

  // Load extraction: pick the lane, then sign- or zero-extend
  always_comb begin
    byte_sel  = rd_bytes[lane_reg];
    half_sel  = lane_reg[1] ? {rd_bytes[3], rd_bytes[2]} : {rd_bytes[1], rd_bytes[0]};
    load_word = rdbuf_next;
    case (size_reg)
      SZ_BYTE: load_word = {{24{byte_sel[7] & ~unsigned_reg}}, byte_sel};
      SZ_HALF: load_word = {{16{half_sel[15] & ~unsigned_reg}}, half_sel};
      default: load_word = rdbuf_next;
    endcase
  end

  // Access sequencer: IDLE -> (RD) -> (WR) -> DONE -> IDLE, all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      size_reg        <= SZ_BYTE;
      lane_reg        <= 2'b00;
      we_reg          <= 1'b0;
      unsigned_reg    <= 1'b0;
      wdata_reg       <= 16'h0000;
      rdbuf_reg       <= 32'h0000_0000;
      rsp_valid_reg   <= 1'b0;
      rsp_data_reg    <= 32'h0000_0000;
      rsp_err_reg     <= 1'b0;
      mem_address_reg <= 32'h0000_0000;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      write_data_reg  <= 32'h0000_0000;
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_data_reg  <= 32'h0000_0000;
          if (req_valid) begin
            size_reg     <= req_size;
            lane_reg     <= req_addr[1:0];
            we_reg       <= req_we;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= req_wdata[15:0];
            if (req_error) begin
              // Faulting requests never touch the memory
              state_reg     <= DONE;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= 1'b1;
            end else if (req_word_store) begin
              state_reg       <= WR;
              mem_address_reg <= req_index;
              mem_write_reg   <= 1'b1;
              write_data_reg  <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read
              state_reg       <= RD;
              mem_address_reg <= req_index;
              mem_read_reg    <= 1'b1;
            end
          end
        end
        RD: begin
          rdbuf_reg    <= Read_Data;
          mem_read_reg <= 1'b0;
          if (we_reg) begin
            state_reg      <= WR;
            mem_write_reg  <= 1'b1;
            write_data_reg <= merged_word;
          end else begin
            state_reg     <= DONE;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= load_word;
          end
        end
        WR: begin
          mem_write_reg <= 1'b0;
          state_reg     <= DONE;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          rsp_data_reg  <= 32'h0000_0000;
        end
        DONE: begin
          // Mem_read stays low here so consecutive reads always see an edge
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
          rsp_err_reg   <= 1'b0;
          rsp_data_reg  <= 32'h0000_0000;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scenarios plus randomized traffic, checked
// cycle by cycle against a schedule-based reference model of the access unit.
`timescale 1ns/1ps

module tb_mem_access_unit;

  localparam int MEM_WORDS = 32;
  localparam int ADDR_BITS = 5;
  localparam int SZ        = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] Mem_address;
  logic        Mem_read;
  logic        Mem_write;
  logic [31:0] Write_data;
  logic [31:0] Read_Data = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .Mem_address(Mem_address), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .Write_data(Write_data), .Read_Data(Read_Data)
  );

  // Data memory: writes on negedge, Read_Data refreshes only on read/address change
  logic [31:0] mem [MEM_WORDS];
  always @(negedge clk) if (Mem_write) mem[Mem_address[ADDR_BITS-1:0]] <= Write_data;
  always @(Mem_read or Mem_address) if (Mem_read) Read_Data = mem[Mem_address[ADDR_BITS-1:0]];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  bit [31:0] ref_mem [MEM_WORDS];
  bit        exp_rd [SZ];
  bit        exp_wr [SZ];
  bit        exp_rv [SZ];
  bit        exp_er [SZ];
  bit [31:0] exp_addr [SZ];
  bit [31:0] exp_wd [SZ];
  bit [31:0] exp_rdat [SZ];
  int        busy_until = 0;
  bit        pw_valid = 1'b0;
  int        pw_cycle = 0;
  int        pw_idx = 0;
  bit [31:0] pw_data = '0;

  function automatic bit [31:0] ref_load(bit [31:0] w, bit [1:0] size, bit uns, bit [1:0] lane);
    bit [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * lane[1])) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit [31:0] ref_merge(bit [31:0] w, bit [31:0] wd, bit [1:0] size, bit [1:0] lane);
    int sh;
    bit [31:0] mask;
    if (size == 2'd0) begin
      sh = 8 * lane;
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * lane[1];
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Model: on each edge, decide acceptance and schedule the expected outputs
  always @(posedge clk) begin : model
    int e, idx, lat;
    bit err;
    bit [31:0] a;
    cyc = cyc + 1;
    e = cyc;
    if (reset) begin
      busy_until = e;
      for (int c = e; c < e + 4 && c < SZ; c++) begin
        exp_rd[c] = 0; exp_wr[c] = 0; exp_rv[c] = 0; exp_er[c] = 0;
      end
      if (pw_valid && pw_cycle >= e) pw_valid = 0;
    end else if (req_valid && e > busy_until && e + 3 < SZ) begin
      a   = req_addr;
      idx = int'(a >> 2) % MEM_WORDS;
      err = (req_size == 2'd3) || (req_size == 2'd1 && a[0]) ||
            (req_size == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(4 * MEM_WORDS));
      if (err) begin
        lat = 1;
        exp_rv[e] = 1; exp_er[e] = 1; exp_rdat[e] = 0;
      end else if (!req_we) begin
        lat = 2;
        exp_rd[e] = 1; exp_addr[e] = idx;
        exp_rv[e+1] = 1; exp_er[e+1] = 0;
        exp_rdat[e+1] = ref_load(ref_mem[idx], req_size, req_unsigned, a[1:0]);
      end else if (req_size == 2'd2) begin
        lat = 2;
        exp_wr[e] = 1; exp_addr[e] = idx; exp_wd[e] = req_wdata;
        exp_rv[e+1] = 1; exp_er[e+1] = 0; exp_rdat[e+1] = 0;
        pw_valid = 1; pw_cycle = e; pw_idx = idx; pw_data = req_wdata;
      end else begin
        lat = 3;
        exp_rd[e] = 1; exp_addr[e] = idx;
        exp_wr[e+1] = 1; exp_addr[e+1] = idx;
        exp_wd[e+1] = ref_merge(ref_mem[idx], req_wdata, req_size, a[1:0]);
        exp_rv[e+2] = 1; exp_er[e+2] = 0; exp_rdat[e+2] = 0;
        pw_valid = 1; pw_cycle = e + 1; pw_idx = idx; pw_data = exp_wd[e+1];
      end
      busy_until = e + lat;
    end
  end

  // ---------------- compare + monitor ----------------
  int          rsp_count = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          last_rsp_edge = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_maddr = '0;
  logic [31:0] rsp_data_q [$];
  logic        rsp_err_q [$];

  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (c > 0 && c < SZ) begin
      chk("req_ready", req_ready, c >= busy_until);
      chk("mem_read", Mem_read, exp_rd[c]);
      chk("mem_write", Mem_write, exp_wr[c]);
      chk("rsp_valid", rsp_valid, exp_rv[c]);
      if (exp_rd[c] || exp_wr[c]) chk("mem_address", Mem_address, exp_addr[c]);
      if (exp_wr[c]) chk("write_data", Write_data, exp_wd[c]);
      if (exp_rv[c]) begin
        chk("rsp_data", rsp_data, exp_rdat[c]);
        chk("rsp_err", rsp_err, exp_er[c]);
      end
      if (rsp_valid) begin
        $display("txn %0d: rsp at cycle %0d data=%h err=%b", rsp_count, c, rsp_data, rsp_err);
        rsp_data_q.push_back(rsp_data);
        rsp_err_q.push_back(rsp_err);
        rsp_count++;
        last_rsp_edge = c;
      end
      if (Mem_read) begin rd_pulses++; last_maddr = Mem_address; end
      if (Mem_write) begin wr_pulses++; last_maddr = Mem_address; last_wdata = Write_data; end
      if (pw_valid && pw_cycle == c) begin
        ref_mem[pw_idx] = pw_data;
        pw_valid = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  int acc_edge = 0;

  // Present a request (caller is at a negedge); returns at the negedge after accept
  task automatic issue(input bit we, input bit [1:0] size, input bit uns,
                       input bit [31:0] addr, input bit [31:0] wdata, input bit hold);
    int n;
    n = 0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", req_ready, 1);
    acc_edge = cyc + 1;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int base);
    int n;
    n = 0;
    while (rsp_count <= base && n < 20) begin @(negedge clk); n++; end
    chk("rsp_arrived", 32'(rsp_count - base), 1);
  endtask

  // One isolated transaction returning its response and latency (accept edge = 1)
  task automatic txn(input bit we, input bit [1:0] size, input bit uns,
                     input bit [31:0] addr, input bit [31:0] wdata,
                     output logic [31:0] data, output logic err, output int lat);
    int base;
    base = rsp_count;
    issue(we, size, uns, addr, wdata, 0);
    wait_rsp(base);
    data = (rsp_count > base) ? rsp_data_q[base] : 32'hxxxx_xxxx;
    err  = (rsp_count > base) ? rsp_err_q[base] : 1'bx;
    lat  = last_rsp_edge - acc_edge + 1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] d;
    logic        er;
    int          lat, b_rd, b_wr, b_rsp;
    bit [31:0]   v, a;
    bit [1:0]    sz;
    bit          hold;

    for (int i = 0; i < MEM_WORDS; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_read", Mem_read, 0);
    chk("rst_mem_write", Mem_write, 0);
    chk("rst_mem_address", Mem_address, 0);
    chk("rst_write_data", Write_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // Word store then word load
    txn(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, d, er, lat);
    chk("sw_err", er, 0); chk("sw_lat", lat, 2);
    chk("sw_addr", last_maddr, 4); chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    txn(0, 2'd2, 0, 32'h10, 0, d, er, lat);
    chk("lw_data", d, 32'hDEAD_BEEF); chk("lw_err", er, 0);
    chk("lw_lat", lat, 2); chk("lw_addr", last_maddr, 4);

    // Byte store read-modify-write
    txn(1, 2'd2, 0, 32'h0C, 32'h1122_3344, d, er, lat);
    b_rd = rd_pulses;
    txn(1, 2'd0, 0, 32'h0E, 32'h0000_00AB, d, er, lat);
    chk("sb_lat", lat, 3); chk("sb_err", er, 0);
    chk("sb_wdata", last_wdata, 32'h11AB_3344); chk("sb_reads", rd_pulses - b_rd, 1);

    // Sign and zero extension
    txn(1, 2'd2, 0, 32'h20, 32'h80F0_7F01, d, er, lat);
    txn(0, 2'd0, 0, 32'h23, 0, d, er, lat); chk("lb_lane3", d, 32'hFFFF_FF80);
    txn(0, 2'd0, 1, 32'h23, 0, d, er, lat); chk("lbu_lane3", d, 32'h0000_0080);
    txn(0, 2'd1, 0, 32'h20, 0, d, er, lat); chk("lh_lane0", d, 32'h0000_7F01);
    txn(0, 2'd1, 1, 32'h22, 0, d, er, lat); chk("lhu_lane2", d, 32'h0000_80F0);

    // Error cases: one cycle, no memory activity
    b_rd = rd_pulses; b_wr = wr_pulses;
    txn(0, 2'd2, 0, 32'h02, 0, d, er, lat); chk("lw_mis_err", er, 1); chk("lw_mis_lat", lat, 1);
    txn(0, 2'd1, 0, 32'h01, 0, d, er, lat); chk("lh_mis_err", er, 1); chk("lh_mis_lat", lat, 1);
    txn(1, 2'd2, 0, 32'h80, 32'h1, d, er, lat); chk("sw_oor_err", er, 1); chk("sw_oor_lat", lat, 1);
    txn(0, 2'd3, 0, 32'h04, 0, d, er, lat); chk("ill_size_err", er, 1); chk("ill_size_data", d, 0);
    chk("err_no_read", rd_pulses - b_rd, 0); chk("err_no_write", wr_pulses - b_wr, 0);

    // Back-to-back loads with req_valid held
    b_rsp = rsp_count; b_rd = rd_pulses;
    issue(0, 2'd2, 0, 32'h10, 0, 1);
    issue(0, 2'd2, 0, 32'h0C, 0, 1);
    req_valid = 1'b0;
    wait_rsp(b_rsp + 1);
    if (rsp_count >= b_rsp + 2) begin
      chk("b2b_data0", rsp_data_q[b_rsp], 32'hDEAD_BEEF);
      chk("b2b_data1", rsp_data_q[b_rsp+1], 32'h11AB_3344);
    end
    chk("b2b_reads", rd_pulses - b_rd, 2);

    // Reset during the RD cycle of a byte store
    b_wr = wr_pulses; b_rsp = rsp_count;
    issue(1, 2'd0, 0, 32'h10, 32'h55, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstrd_ready", req_ready, 1);
    chk("rstrd_mem_write", Mem_write, 0);
    repeat (3) @(negedge clk);
    chk("rstrd_no_write", wr_pulses - b_wr, 0);
    chk("rstrd_no_rsp", rsp_count - b_rsp, 0);
    chk("rstrd_word", mem[4], 32'hDEAD_BEEF);

    // Reset during the WR cycle of a word store: the write still lands
    b_rsp = rsp_count;
    issue(1, 2'd2, 0, 32'h14, 32'h1234_5678, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstwr_mem_write", Mem_write, 0);
    repeat (3) @(negedge clk);
    chk("rstwr_word", mem[5], 32'h1234_5678);
    chk("rstwr_no_rsp", rsp_count - b_rsp, 0);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      sz = ($urandom_range(0, 9) == 9) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 4 * MEM_WORDS + 7);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      hold = ($urandom_range(0, 2) == 0);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < MEM_WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
